// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type, digit width and minimum-digit helper for bin2bcd_seq
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DIGIT_W = 4;

    function automatic int min_digits(input int w);
        longint lim = longint'(1) << w;
        longint p   = 1;
        int     d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (p < lim) begin
                p = p * 10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5..9
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter; define BIN2BCD_SIGNED_EN for two's complement input
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_neg,
    output logic                      busy
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = DIGIT_W * DIGITS;

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $fatal(1, "bin2bcd_seq: BIN_W must be within 4..32");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $fatal(1, "bin2bcd_seq: DIGITS too small for BIN_W");
    end

    state_t            state;
    logic [BIN_W-1:0]  bin;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     adj;
    logic [CW-1:0]     cnt;
    logic [BW+BIN_W-1:0] sh;
    logic [BIN_W-1:0]  ld;
    logic              acc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d(bcd[DIGIT_W*g +: DIGIT_W]),
            .q(adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign sh        = {adj, bin} << 1;
    assign acc       = in_valid && in_ready;
    assign out_bcd   = bcd;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

`ifdef BIN2BCD_SIGNED_EN
    // Negating in BIN_W bits maps the most negative value onto its own unsigned magnitude
    assign ld = in_bin[BIN_W-1] ? ~in_bin + BIN_W'(1) : in_bin;
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_neg <= 1'b0;
        else if (acc)
            out_neg <= in_bin[BIN_W-1];
    end
`else
    assign ld      = in_bin;
    assign out_neg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= !acc;
                    if (acc) begin
                        bin   <= ld;
                        bcd   <= '0;
                        cnt   <= CW'(BIN_W);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= sh;
                    cnt        <= cnt - CW'(1);
                    state      <= (cnt == CW'(1)) ? DONE : SHIFT;
                end
                DONE: begin
                    in_ready <= out_ready;
                    state    <= out_ready ? IDLE : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vectors plus an arithmetic reference model checked every result cycle
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_bcd;
    logic        out_neg;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [19:0] exp_bcd = '0;
    logic        exp_neg = 1'b0;
    logic        prev_ov = 1'b0;
    int          rise_cyc[$];
    logic [19:0] rise_bcd[$];

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_neg(out_neg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] bcd_of(input logic [15:0] v);
        logic [19:0] r = '0;
`ifdef BIN2BCD_SIGNED_EN
        longint m = v[15] ? 65536 - longint'(v) : longint'(v);
`else
        longint m = longint'(v);
`endif
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic neg_of(input logic [15:0] v);
`ifdef BIN2BCD_SIGNED_EN
        return v[15];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready) begin
            exp_bcd = bcd_of(in_bin);
            exp_neg = neg_of(in_bin);
            acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("model_bcd", out_bcd, exp_bcd);
            chk("model_neg", out_neg, exp_neg);
            chk("ready_low_in_done", in_ready, 0);
            chk("busy_in_done", busy, 1);
            if (!prev_ov) begin
                chk("latency", cyc - acc_cyc, 16);
                rise_cyc.push_back(cyc);
                rise_bcd.push_back(out_bcd);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [15:0] v);
        in_bin = v;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("done_timeout", out_valid, 1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_handshake", in_ready, 1);
        chk("valid_after_handshake", out_valid, 0);
    endtask

`ifdef BIN2BCD_SIGNED_EN
    logic [15:0] vin[3]  = '{16'h8000, 16'hFFFF, 16'h7FFF};
    logic [19:0] vexp[3] = '{20'h32768, 20'h00001, 20'h32767};
    logic        vneg[3] = '{1'b1, 1'b1, 1'b0};
`else
    logic [15:0] vin[4]  = '{16'h0000, 16'hFFFF, 16'h000F, 16'd9999};
    logic [19:0] vexp[4] = '{20'h00000, 20'h65535, 20'h00015, 20'h09999};
    logic        vneg[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_bcd", out_bcd, 0);
        chk("rst_out_neg", out_neg, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);

        foreach (vin[k]) begin
            send(vin[k]);
            wait_done();
            chk("vec_bcd", out_bcd, vexp[k]);
            chk("vec_neg", out_neg, vneg[k]);
            release_result();
        end

        send(16'd500);
        wait_done();
        for (int k = 0; k < 10; k++) begin
            in_bin = (k == 3) ? 16'd777 : 16'd500;
            in_valid = (k == 3);
            @(negedge clk);
            chk("hold_bcd", out_bcd, 20'h00500);
            chk("hold_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release_result();

        send(16'd1234);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_bcd", out_bcd, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_release", in_ready, 1);
        send(16'd42);
        wait_done();
        chk("after_rst_bcd", out_bcd, 20'h00042);
        release_result();

        rise_cyc.delete();
        rise_bcd.delete();
        out_ready = 1'b1;
        in_bin = 16'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && rise_cyc.size() < 2; i++) begin
            @(negedge clk);
            if (busy && in_bin == 16'd100 && rise_cyc.size() == 0) in_bin = 16'd7;
            if (rise_cyc.size() == 1 && busy && !out_valid) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_count", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) begin
            chk("b2b_first", rise_bcd[0], 20'h00100);
            chk("b2b_second", rise_bcd[1], 20'h00007);
            chk("b2b_spacing", rise_cyc[1] - rise_cyc[0], 18);
        end
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
